pc_salto_ras: RTL and testbench

- Parametrised successor to the single-cycle program counter: generalised width, reset vector, increment and branch shift.
- Adds beq/bne selection, absolute jump, register jump, stall and a circular return-address stack (RAS) for call/return.
- Sits at the fetch front of the monocycle processor. Drives direinstru to instruction memory.
- Takes control from the control unit and oZero from the ALU.

---
 rtl/pc_pkg.sv | 17 +
 rtl/ras_circ.sv | 46 ++++
 rtl/pc_salto_ras.sv | 103 ++++++++++
 tb/tb_pc_salto_ras.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants for the fetch-stage program counter.
package pc_pkg;

  // Next-PC source select, lowest to highest priority
  typedef enum logic [2:0] {
    SRC_SEQ = 3'd0,
    SRC_BR  = 3'd1,
    SRC_J   = 3'd2,
    SRC_JR  = 3'd3,
    SRC_RET = 3'd4
  } pc_src_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_INC   = 4;
  localparam int DEF_SHIFT = 2;

endpackage

// File: rtl/ras_circ.sv
// Circular return-address stack: pushing while full overwrites the oldest entry.
module ras_circ #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             vacia,
  output logic             llena
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [RAS_DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]                   ptr_q;
  logic [PW-1:0]                   ptr_up;
  logic [CW-1:0]                   cnt_q;

  // ptr_q points at the current top; a push writes one slot above it
  assign ptr_up = ptr_q + PW'(1);
  assign top    = mem_q[ptr_q];
  assign vacia  = (cnt_q == '0);
  assign llena  = (cnt_q == CW'(RAS_DEPTH));

  // Pointer, saturating count and storage; push has priority over pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      mem_q[ptr_up] <= din;
      ptr_q         <= ptr_up;
      if (!llena) cnt_q <= cnt_q + CW'(1);
    end else if (pop && !vacia) begin
      ptr_q <= ptr_q - PW'(1);
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/pc_salto_ras.sv
// Fetch program counter with branches, jumps, stall and a return-address stack.
module pc_salto_ras
  import pc_pkg::*;
#(
  parameter int                 WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int                 INC          = DEF_INC,
  parameter int                 SHIFT        = DEF_SHIFT,
  parameter int                 RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             SaltoCond,
  input  logic             SaltoNeg,
  input  logic             oZero,
  input  logic [WIDTH-1:0] extSigno,
  input  logic             SaltoIncond,
  input  logic [25:0]      indiceSalto,
  input  logic             SaltoReg,
  input  logic [WIDTH-1:0] regDir,
  input  logic             Llamada,
  input  logic             Retorno,
  output logic [WIDTH-1:0] direinstru,
  output logic [WIDTH-1:0] pcMas,
  output logic             rasVacia,
  output logic             rasLlena,
  output logic             errAlin,
  output logic             errRas
);

  localparam int               LOW   = 26 + SHIFT;
  localparam int               JW    = WIDTH + LOW;
  localparam logic [WIDTH-1:0] AL_M  = WIDTH'((64'd1 << SHIFT) - 64'd1);

  logic [WIDTH-1:0] pc_q, pc_d, next_pc, jmp_pc, ras_top;
  logic             errAlin_q, errAlin_d, errRas_q, errRas_d;
  logic             ras_push, ras_pop;
  pc_src_e          src;

  assign direinstru = pc_q;
  assign pcMas      = pc_q + WIDTH'(INC);
  assign errAlin    = errAlin_q;
  assign errRas     = errRas_q;

  // Absolute jump target: keep the PC bits above the index field
  if (WIDTH > LOW) begin : g_jmp_hi
    assign jmp_pc = {pcMas[WIDTH-1:LOW], LOW'(LOW'(indiceSalto) << SHIFT)};
  end else begin : g_jmp_trunc
    assign jmp_pc = WIDTH'(JW'(indiceSalto) << SHIFT);
  end

  // Stall freezes the stack; Retorno suppresses any push
  assign ras_push = !stall && Llamada && !Retorno;
  assign ras_pop  = !stall && Retorno && !rasVacia;

  ras_circ #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .rst   (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pcMas),
    .top   (ras_top),
    .vacia (rasVacia),
    .llena (rasLlena)
  );

  // Prioritised next-PC selection and sticky error updates
  always_comb begin
    src = SRC_SEQ;
    if (Retorno)                             src = rasVacia ? SRC_SEQ : SRC_RET;
    else if (SaltoReg)                       src = SRC_JR;
    else if (SaltoIncond)                    src = SRC_J;
    else if (SaltoCond && (oZero ^ SaltoNeg)) src = SRC_BR;

    case (src)
      SRC_RET: next_pc = ras_top;
      SRC_JR:  next_pc = regDir;
      SRC_J:   next_pc = jmp_pc;
      SRC_BR:  next_pc = pcMas + (extSigno << SHIFT);
      default: next_pc = pcMas;
    endcase

    pc_d      = stall ? pc_q : next_pc;
    errAlin_d = errAlin_q | (!stall && (src == SRC_JR || src == SRC_RET) &&
                             ((next_pc & AL_M) != '0));
    errRas_d  = errRas_q | (!stall && Retorno && rasVacia);
  end

  // PC and error flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_VECTOR;
      errAlin_q <= 1'b0;
      errRas_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      errAlin_q <= errAlin_d;
      errRas_q  <= errRas_d;
    end
  end

endmodule

// File: tb/tb_pc_salto_ras.sv
// Directed vector bench for pc_salto_ras with default parameters.
module tb_pc_salto_ras;

  logic        clk = 1'b0, reset = 1'b1, stall = 1'b0;
  logic        SaltoCond = 0, SaltoNeg = 0, oZero = 0, SaltoIncond = 0, SaltoReg = 0;
  logic        Llamada = 0, Retorno = 0;
  logic [31:0] extSigno = '0, regDir = '0;
  logic [25:0] indiceSalto = '0;
  logic [31:0] direinstru, pcMas;
  logic        rasVacia, rasLlena, errAlin, errRas;

  int n_cmp = 0, n_err = 0;

  pc_salto_ras dut (
    .clk(clk), .reset(reset), .stall(stall), .SaltoCond(SaltoCond), .SaltoNeg(SaltoNeg),
    .oZero(oZero), .extSigno(extSigno), .SaltoIncond(SaltoIncond), .indiceSalto(indiceSalto),
    .SaltoReg(SaltoReg), .regDir(regDir), .Llamada(Llamada), .Retorno(Retorno),
    .direinstru(direinstru), .pcMas(pcMas), .rasVacia(rasVacia), .rasLlena(rasLlena),
    .errAlin(errAlin), .errRas(errRas)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic c, n, z, j, r, call, ret;
    logic [31:0] ext, rdir;
    logic [25:0] idx;
    logic [31:0] exp_pc;
    logic        exp_vac;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic c, logic n, logic z, logic [31:0] ext, logic j,
                              logic [25:0] idx, logic r, logic [31:0] rdir, logic call,
                              logic ret, logic [31:0] exp_pc, logic exp_vac);
    vec_t v;
    v.c = c; v.n = n; v.z = z; v.ext = ext; v.j = j; v.idx = idx; v.r = r; v.rdir = rdir;
    v.call = call; v.ret = ret; v.exp_pc = exp_pc; v.exp_vac = exp_vac;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    stall = 0; SaltoCond = 0; SaltoNeg = 0; oZero = 0; extSigno = '0; SaltoIncond = 0;
    indiceSalto = '0; SaltoReg = 0; regDir = '0; Llamada = 0; Retorno = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_state(string nm, logic [31:0] pc, logic vac, logic lle, logic ea, logic er);
    chk({nm, ".pc"}, direinstru, pc);
    chk({nm, ".pcMas"}, pcMas, pc + 32'd4);
    chk({nm, ".vacia"}, {31'd0, rasVacia}, {31'd0, vac});
    chk({nm, ".llena"}, {31'd0, rasLlena}, {31'd0, lle});
    chk({nm, ".errAlin"}, {31'd0, errAlin}, {31'd0, ea});
    chk({nm, ".errRas"}, {31'd0, errRas}, {31'd0, er});
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    reset = 1'b1; #1;
    chk("rst_async.pc", direinstru, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    //            c  n  z  ext           j  idx         r  rdir          call ret exp_pc         vac
    tbl[0]  = mk(0, 0, 0, 32'd0,        0, 26'h0,      0, 32'h0,        0,  0,  32'h4,         1);
    tbl[1]  = mk(0, 0, 0, 32'd0,        0, 26'h0,      0, 32'h0,        0,  0,  32'h8,         1);
    tbl[2]  = mk(1, 0, 1, 32'd1,        0, 26'h0,      0, 32'h0,        0,  0,  32'h10,        1);
    tbl[3]  = mk(1, 0, 1, 32'hFFFFFFFD, 0, 26'h0,      0, 32'h0,        0,  0,  32'h8,         1);
    tbl[4]  = mk(1, 1, 1, 32'd1,        0, 26'h0,      0, 32'h0,        0,  0,  32'hC,         1);
    tbl[5]  = mk(1, 1, 0, 32'd0,        0, 26'h0,      0, 32'h0,        0,  0,  32'h10,        1);
    tbl[6]  = mk(0, 0, 0, 32'd0,        1, 26'h40,     0, 32'h0,        1,  0,  32'h100,       0);
    tbl[7]  = mk(0, 0, 0, 32'd0,        0, 26'h0,      0, 32'h0,        0,  0,  32'h104,       0);
    tbl[8]  = mk(0, 0, 0, 32'd0,        0, 26'h0,      0, 32'h0,        0,  1,  32'h14,        1);
    tbl[9]  = mk(0, 0, 0, 32'd0,        1, 26'h3FFFFFF,0, 32'h0,        0,  0,  32'h0FFFFFFC,  1);
    tbl[10] = mk(0, 0, 0, 32'd0,        0, 26'h0,      0, 32'h0,        0,  0,  32'h10000000,  1);
    tbl[11] = mk(0, 0, 0, 32'd0,        1, 26'h100,    0, 32'h0,        0,  0,  32'h10000400,  1);
    tbl[12] = mk(0, 0, 0, 32'd0,        0, 26'h0,      1, 32'hFFFFFFFC, 0,  0,  32'hFFFFFFFC,  1);
    tbl[13] = mk(0, 0, 0, 32'd0,        0, 26'h0,      0, 32'h0,        0,  0,  32'h0,         1);
    tbl[14] = mk(1, 0, 1, 32'd7,        1, 26'h99,     1, 32'h40,       0,  0,  32'h40,        1);
    tbl[15] = mk(1, 0, 1, 32'd5,        1, 26'h20,     0, 32'h0,        0,  0,  32'h80,        1);

    clr();
    #100;
    chk_state("reset", 32'h0, 1, 0, 0, 0);
    @(negedge clk); reset = 1'b0;

    // Table: inputs set after one edge, result checked after the next
    for (int i = 0; i < 16; i++) begin
      SaltoCond = tbl[i].c; SaltoNeg = tbl[i].n; oZero = tbl[i].z; extSigno = tbl[i].ext;
      SaltoIncond = tbl[i].j; indiceSalto = tbl[i].idx; SaltoReg = tbl[i].r;
      regDir = tbl[i].rdir; Llamada = tbl[i].call; Retorno = tbl[i].ret;
      step();
      chk_state($sformatf("vec%0d", i), tbl[i].exp_pc, tbl[i].exp_vac, 0, 0, 0);
    end
    clr();

    // Five standalone calls on a 4-deep stack: the oldest (0x4) is overwritten
    pulse_reset();
    Llamada = 1;
    step(); chk_state("call1", 32'h4, 0, 0, 0, 0);
    step(); chk_state("call2", 32'h8, 0, 0, 0, 0);
    step(); chk_state("call3", 32'hC, 0, 0, 0, 0);
    step(); chk_state("call4", 32'h10, 0, 1, 0, 0);
    step(); chk_state("call5", 32'h14, 0, 1, 0, 0);
    Llamada = 0; Retorno = 1;
    step(); chk_state("ret1", 32'h14, 0, 0, 0, 0);
    step(); chk_state("ret2", 32'h10, 0, 0, 0, 0);
    step(); chk_state("ret3", 32'hC, 0, 0, 0, 0);
    Llamada = 1;                      // Retorno wins, no push
    step(); chk_state("ret4_call", 32'h8, 1, 0, 0, 0);
    Llamada = 0;
    step(); chk_state("ret_empty", 32'hC, 1, 0, 0, 1);
    clr();

    // Misaligned register jump sets a sticky flag
    SaltoReg = 1; regDir = 32'h22;
    step(); chk_state("jr_mis", 32'h22, 1, 0, 1, 1);
    clr();
    step(); chk_state("jr_sticky", 32'h26, 1, 0, 1, 1);

    // Stall holds PC and stack, then async reset during stall
    pulse_reset();
    Llamada = 1;
    step(); chk_state("st_call", 32'h4, 0, 0, 0, 0);
    stall = 1; SaltoCond = 1; oZero = 1; extSigno = 32'd8;
    step(); chk_state("stall1", 32'h4, 0, 0, 0, 0);
    step(); chk_state("stall2", 32'h4, 0, 0, 0, 0);
    clr(); Retorno = 1;
    step(); chk_state("st_ret", 32'h4, 1, 0, 0, 0);
    clr(); SaltoReg = 1; regDir = 32'h200; stall = 1;
    step(); chk_state("stall_jr", 32'h4, 1, 0, 0, 0);
    #2; reset = 1'b1; #1;
    chk_state("rst_mid_stall", 32'h0, 1, 0, 0, 0);
    @(negedge clk); reset = 1'b0;
    clr();
    step(); chk_state("post_rst", 32'h4, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
